text_line_ctrl: RTL and testbench

- Sequences the 12x16 glyph renderer (`letter`) to draw a string of character codes on the 160x120 VGA framebuffer.
- Latches a string, origin and colour, then for each non-space character:
  - presents the character code to the font ROM,
  - drives the renderer's start/done handshake,
  - advances the cursor, wrapping lines and clipping at the screen bottom.
- Sits between the GUI screen FSM (upstream start/done) and the `letter` block plus font ROM (downstream).

---
 rtl/text_line_ctrl.sv | 129 ++++++++++++
 tb/tb_text_line_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_ctrl.sv
// Draws a latched string of glyph codes through the letter renderer, one
// glyph at a time, advancing the cursor with line wrap and bottom clipping.
module text_line_ctrl #(
  parameter int MAX_CHARS  = 16,
  parameter int LEN_W      = 5,
  parameter int CHAR_PITCH = 12,
  parameter int LINE_PITCH = 16,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*MAX_CHARS-1:0] text,
  input  logic [LEN_W-1:0]       len,
  input  logic [7:0]             x0,
  input  logic [6:0]             y0,
  input  logic [2:0]             colour,
  output logic                   done,
  output logic                   busy,
  output logic                   clipped,
  output logic [7:0]             char_code,
  output logic                   lt_start,
  output logic [7:0]             lt_x,
  output logic [6:0]             lt_y,
  output logic [2:0]             lt_colour,
  input  logic                   lt_done
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] ISSUE   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;
  localparam logic [2:0] ADVANCE = 3'd5;
  localparam logic [2:0] FINISH  = 3'd6;
  localparam int GLYPH_H = 16;

  logic [2:0]             state;
  logic [8*MAX_CHARS-1:0] text_q;
  logic [LEN_W-1:0]       len_q, idx, len_cl;
  logic [7:0]             x0_q, cur_x, cur_char;
  logic [6:0]             cur_y;
  logic [2:0]             col_q;
  logic [8:0]             nx, ny_bot;
  logic [7:0]             ny;
  logic                   last;

  assign len_cl   = (len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : len;
  assign cur_char = text_q[8*idx +: 8];
  assign last     = (idx == len_q - LEN_W'(1));
  // Right edge test looks one glyph ahead: the next glyph must end on-screen.
  assign nx       = {1'b0, cur_x} + 9'(2*CHAR_PITCH);
  assign ny       = {1'b0, cur_y} + 8'(LINE_PITCH);
  assign ny_bot   = {1'b0, ny} + 9'(GLYPH_H);

  assign done = (state == FINISH);
  assign busy = (state != IDLE) && (state != FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clipped   <= 1'b0;
      lt_start  <= 1'b0;
      char_code <= '0;
      lt_x      <= '0;
      lt_y      <= '0;
      lt_colour <= '0;
      idx       <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      text_q    <= '0;
      len_q     <= '0;
      x0_q      <= '0;
      col_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          text_q  <= text;
          len_q   <= len_cl;
          x0_q    <= x0;
          col_q   <= colour;
          cur_x   <= x0;
          cur_y   <= y0;
          idx     <= '0;
          clipped <= 1'b0;
          state   <= (len == '0) ? FINISH : LOAD;
        end
        LOAD: begin
          char_code <= cur_char;
          lt_x      <= cur_x;
          lt_y      <= cur_y;
          lt_colour <= col_q;
          state     <= (cur_char == 8'h20) ? ADVANCE : ISSUE;
        end
        ISSUE: begin
          lt_start <= 1'b1;
          state    <= WAIT;
        end
        WAIT: if (lt_done) begin
          lt_start <= 1'b0;
          state    <= GAP;
        end
        GAP: state <= ADVANCE;
        ADVANCE: begin
          if (last) begin
            state <= FINISH;
          end else begin
            idx <= idx + LEN_W'(1);
            if (nx <= 9'(SCREEN_W)) begin
              cur_x <= cur_x + 8'(CHAR_PITCH);
              state <= LOAD;
            end else begin
              cur_x <= x0_q;
              cur_y <= ny[6:0];
              if (ny_bot > 9'(SCREEN_H)) begin
                clipped <= 1'b1;
                state   <= FINISH;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        FINISH: if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_line_ctrl.sv
// Self-checking bench for text_line_ctrl: renderer model plus a reference
// model computing glyph positions, gaps and clipping from the drawing rules.
module tb_text_line_ctrl;
  logic         clk = 0, rst = 0, start = 0;
  logic [127:0] text = '0;
  logic [4:0]   len = '0;
  logic [7:0]   x0 = '0;
  logic [6:0]   y0 = '0;
  logic [2:0]   colour = '0;
  logic         done, busy, clipped, lt_start, lt_done = 0;
  logic [7:0]   char_code, lt_x;
  logic [6:0]   lt_y;
  logic [2:0]   lt_colour;

  int errors = 0, checks = 0;

  text_line_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .text(text), .len(len), .x0(x0),
    .y0(y0), .colour(colour), .done(done), .busy(busy), .clipped(clipped),
    .char_code(char_code), .lt_start(lt_start), .lt_x(lt_x), .lt_y(lt_y),
    .lt_colour(lt_colour), .lt_done(lt_done)
  );

  always #5 clk = ~clk;

  // Renderer model (done 5 cycles after start) and pulse monitor.
  int   rcnt = 0, low_cnt = 0, unstable = 0;
  logic prev_st = 0;
  logic [7:0] held_c, held_x;
  logic [6:0] held_y;
  int mon_x[$], mon_y[$], mon_c[$], mon_col[$], mon_gap[$];

  always @(negedge clk) begin
    if (lt_start) begin
      rcnt = rcnt + 1;
      lt_done = (rcnt >= 5);
      if (!prev_st) begin
        mon_x.push_back(lt_x); mon_y.push_back(lt_y); mon_c.push_back(char_code);
        mon_col.push_back(lt_colour); mon_gap.push_back(low_cnt);
      end else if (char_code !== held_c || lt_x !== held_x || lt_y !== held_y)
        unstable = unstable + 1;
      held_c = char_code; held_x = lt_x; held_y = lt_y;
      low_cnt = 0;
    end else begin
      rcnt = 0; lt_done = 0;
      low_cnt = low_cnt + 1;
    end
    prev_st = lt_start;
  end

  // Reference model: expected glyphs, gaps between pulses, and clip flag.
  int exp_x[$], exp_y[$], exp_c[$], exp_gap[$];
  bit exp_clip;

  task automatic model(input logic [127:0] t, input int n, input int ox, input int oy);
    int cx, cy, spaces;
    exp_x.delete(); exp_y.delete(); exp_c.delete(); exp_gap.delete();
    exp_clip = 0; cx = ox; cy = oy; spaces = 0;
    if (n > 16) n = 16;
    for (int i = 0; i < n; i++) begin
      if (t[8*i +: 8] == 8'h20) spaces++;
      else begin
        exp_x.push_back(cx); exp_y.push_back(cy); exp_c.push_back(t[8*i +: 8]);
        exp_gap.push_back(4 + 2*spaces);
        spaces = 0;
      end
      if (i == n-1) break;
      if (cx + 24 <= 160) cx += 12;
      else begin
        cx = ox; cy += 16;
        if (cy + 16 > 120) begin exp_clip = 1; break; end
      end
    end
  endtask

  function automatic logic [127:0] pack(input string s);
    logic [127:0] r = '0;
    for (int i = 0; i < s.len() && i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic clear_mon();
    mon_x.delete(); mon_y.delete(); mon_c.delete(); mon_col.delete(); mon_gap.delete();
    unstable = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; start = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 0 || busy !== 0 || clipped !== 0 || lt_start !== 0 ||
        char_code !== 0 || lt_x !== 0 || lt_y !== 0 || lt_colour !== 0) begin
      errors++;
      $display("FAIL reset: done=%b busy=%b clip=%b st=%b code=%h x=%0d y=%0d col=%0d, need all 0",
               done, busy, clipped, lt_start, char_code, lt_x, lt_y, lt_colour);
    end
    rst = 0;
  endtask

  // Draw one string and compare every glyph, gap and flag to the model.
  task automatic test_string(input string nm, input logic [127:0] t, input int n,
                             input int ox, input int oy, input logic [2:0] col);
    int cyc;
    clear_mon();
    model(t, n, ox, oy);
    @(negedge clk);
    text = t; len = 5'(n); x0 = 8'(ox); y0 = 7'(oy); colour = col; start = 1;
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout: done=%b need 1", nm, done); end
    checks++;
    if (clipped !== exp_clip) begin
      errors++; $display("FAIL %s clipped: got %b need %b", nm, clipped, exp_clip);
    end
    checks++;
    if (mon_x.size() != exp_x.size()) begin
      errors++; $display("FAIL %s pulses: got %0d need %0d", nm, mon_x.size(), exp_x.size());
    end else begin
      for (int i = 0; i < exp_x.size(); i++) begin
        checks++;
        if (mon_x[i] != exp_x[i] || mon_y[i] != exp_y[i] || mon_c[i] != exp_c[i] ||
            mon_col[i] != int'(col)) begin
          errors++;
          $display("FAIL %s glyph%0d: got (%0d,%0d) %h col%0d need (%0d,%0d) %h col%0d", nm, i,
                   mon_x[i], mon_y[i], mon_c[i], mon_col[i], exp_x[i], exp_y[i], exp_c[i], col);
        end
        if (i > 0) begin
          checks++;
          if (mon_gap[i] != exp_gap[i]) begin
            errors++; $display("FAIL %s gap%0d: got %0d need %0d", nm, i, mon_gap[i], exp_gap[i]);
          end
        end
      end
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL %s stable: %0d changes need 0", nm, unstable); end
    start = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 0) begin errors++; $display("FAIL %s done_drop: got %b need 0", nm, done); end
  endtask

  task automatic test_abc();
    test_string("abc", pack("ABC"), 3, 10, 20, 3'b101);
    checks++;
    if (mon_x.size() != 3 || mon_x[0] != 10 || mon_x[1] != 22 || mon_x[2] != 34 ||
        mon_c[1] != 8'h42) begin
      errors++; $display("FAIL abc_const: got %0d pulses, need x=10,22,34", mon_x.size());
    end
  endtask

  task automatic test_space();
    test_string("space", pack("A B"), 3, 10, 20, 3'b011);
    checks++;
    if (mon_x.size() != 2 || mon_x[1] != 34 || mon_gap[1] != 6) begin
      errors++; $display("FAIL space_const: got %0d pulses, need 2 with x1=34 gap=6", mon_x.size());
    end
  endtask

  task automatic test_wrap();
    test_string("wrap", pack("WXYZ"), 4, 130, 0, 3'b001);
    checks++;
    if (mon_x.size() != 4 || mon_x[2] != 130 || mon_y[2] != 16 || mon_y[3] != 16) begin
      errors++; $display("FAIL wrap_const: got %0d pulses, need wrap to (130,16)", mon_x.size());
    end
  endtask

  task automatic test_clip();
    test_string("clip", pack("KLMN"), 4, 140, 96, 3'b110);
    checks++;
    if (mon_x.size() != 1 || mon_x[0] != 140 || mon_y[0] != 96) begin
      errors++; $display("FAIL clip_const: got %0d pulses, need one at (140,96)", mon_x.size());
    end
  endtask

  task automatic test_len0();
    int cyc;
    clear_mon();
    @(negedge clk); text = pack("Q"); len = 0; start = 1;
    cyc = 0;
    while (!done && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (!done || cyc > 2) begin errors++; $display("FAIL len0_done: got done=%b after %0d cycles need 1 within 2", done, cyc); end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1 || mon_x.size() != 0) begin
      errors++; $display("FAIL len0_hold: got done=%b pulses=%0d need 1 and 0", done, mon_x.size());
    end
    start = 0;
    @(negedge clk);
    checks++;
    if (done !== 0 || busy !== 0) begin errors++; $display("FAIL len0_idle: got done=%b busy=%b need 0", done, busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_mon();
    @(negedge clk); text = pack("XYZ"); len = 3; x0 = 20; y0 = 40; colour = 3'b010; start = 1;
    cyc = 0;
    while (mon_x.size() < 2 && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (mon_x.size() < 2) begin errors++; $display("FAIL mid_reach: got %0d pulses need 2", mon_x.size()); end
    rst = 1; start = 0;
    @(negedge clk);
    checks++;
    if (lt_start !== 0 || busy !== 0 || done !== 0) begin
      errors++; $display("FAIL mid_reset: got st=%b busy=%b done=%b need 0", lt_start, busy, done);
    end
    rst = 0;
    test_string("redraw", pack("XYZ"), 3, 20, 40, 3'b010);
    checks++;
    if (mon_c.size() == 0 || mon_c[0] != 8'h58) begin
      errors++; $display("FAIL redraw_first: got %0d pulses, need first code 58", mon_c.size());
    end
  endtask

  task automatic test_random();
    logic [127:0] t;
    int n;
    for (int k = 0; k < 8; k++) begin
      t = '0;
      for (int i = 0; i < 16; i++)
        t[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h20 : 8'(8'h41 + $urandom_range(0, 25));
      n = $urandom_range(1, 20);
      test_string($sformatf("rand%0d", k), t, n, $urandom_range(0, 159), $urandom_range(0, 119),
                  3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_space();
    test_wrap();
    test_clip();
    test_len0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
